// File: rtl/vga_pattern_sequencer.sv
// Test-pattern sequencer for the 480p HDMI path: frame-synchronous pattern advance, one black
// frame between patterns, 2-cycle aligned outputs. Optional moving box: PATTERN_SEQ_MOVING_BOX_EN.
module vga_pattern_sequencer #(
  parameter int H_ACTIVE           = 640,
  parameter int V_ACTIVE           = 480,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int BAR_WIDTH          = 80
) (
  input  logic       i_pix_clk,
  input  logic       i_pix_rst,
  input  logic [9:0] i_sx,
  input  logic [9:0] i_sy,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_de,
  input  logic       i_next,
  input  logic       i_auto,
  output logic [3:0] o_red_4b,
  output logic [3:0] o_green_4b,
  output logic [3:0] o_blue_4b,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_de,
  output logic [1:0] o_pattern
);

  localparam int FCNT_W = $clog2(FRAMES_PER_PATTERN);
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FRAMES_PER_PATTERN - 1);

  typedef enum logic [0:0] {ST_SHOW = 1'b0, ST_BLANK = 1'b1} state_t;

  state_t            state_r, state_next_s;
  logic [1:0]        pat_r, pat_next_s;
  logic [FCNT_W-1:0] fcnt_r, fcnt_next_s;
  logic              pending_r, pending_next_s;
  logic              fs_s, auto_req_s;

  logic       hsync1_r, vsync1_r, de1_r, blank1_r, check1_r, win1_r;
  logic [1:0] pat1_r;
  logic [2:0] bar_k1_r, bar_k_s;
  logic [3:0] ramp1_r;
  logic       in_win_s;
  logic [3:0] red_s, green_s, blue_s;

  assign fs_s       = (i_sx == 10'd0) && (i_sy == 10'd0);
  assign auto_req_s = i_auto && (fcnt_r == FCNT_MAX);
  assign bar_k_s    = 3'(i_sx / 10'(BAR_WIDTH));
  assign in_win_s   = ({1'b0, i_sx} < 11'(H_ACTIVE)) && ({1'b0, i_sy} < 11'(V_ACTIVE));
  assign o_pattern  = pat_r;

  // Next-state logic: pattern changes and blank insertion happen only at frame start
  always_comb begin
    state_next_s   = state_r;
    pat_next_s     = pat_r;
    fcnt_next_s    = fcnt_r;
    pending_next_s = pending_r | i_next;
    case (state_r)
      ST_SHOW: begin
        if (fs_s) begin
          if (pending_r || i_next || auto_req_s) begin
            pat_next_s     = pat_r + 2'd1;
            pending_next_s = 1'b0;
            fcnt_next_s    = '0;
            state_next_s   = ST_BLANK;
          end else if (fcnt_r != FCNT_MAX) begin
            fcnt_next_s = fcnt_r + FCNT_W'(1);
          end else begin
            fcnt_next_s = fcnt_r;
          end
        end else begin
          state_next_s = ST_SHOW;
        end
      end
      ST_BLANK: begin
        if (fs_s) begin
          state_next_s = ST_SHOW;
          fcnt_next_s  = '0;
        end else begin
          state_next_s = ST_BLANK;
        end
      end
      default: begin
        state_next_s = ST_SHOW;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge i_pix_clk) begin
    if (i_pix_rst) begin
      state_r   <= ST_SHOW;
      pat_r     <= 2'd0;
      fcnt_r    <= '0;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      pat_r     <= pat_next_s;
      fcnt_r    <= fcnt_next_s;
      pending_r <= pending_next_s;
    end
  end

`ifdef PATTERN_SEQ_MOVING_BOX_EN
  logic [9:0] box_x_r, box_x_next_s;
  logic       box_wrap_s, box_hit_s, box1_r;

  assign box_wrap_s = ({1'b0, box_x_r} + 11'd2) > 11'(H_ACTIVE - 32);
  assign box_hit_s  = ({1'b0, i_sx} >= {1'b0, box_x_next_s}) &&
                      ({1'b0, i_sx} <= ({1'b0, box_x_next_s} + 11'd31)) &&
                      (i_sy >= 10'd224) && (i_sy <= 10'd255);

  // Box steps once per frame and restarts at the left edge before it would leave the screen
  always_comb begin
    box_x_next_s = box_x_r;
    if (fs_s) begin
      if (box_wrap_s) begin
        box_x_next_s = 10'd0;
      end else begin
        box_x_next_s = box_x_r + 10'd2;
      end
    end else begin
      box_x_next_s = box_x_r;
    end
  end

  // Box position register and its per-pixel hit flag in stage 1
  always_ff @(posedge i_pix_clk) begin
    if (i_pix_rst) begin
      box_x_r <= 10'd0;
      box1_r  <= 1'b0;
    end else begin
      box_x_r <= box_x_next_s;
      box1_r  <= box_hit_s;
    end
  end
`endif

  // Stage 1: sync/DE, pattern decode, and the frame state that applies to this pixel
  always_ff @(posedge i_pix_clk) begin
    if (i_pix_rst) begin
      hsync1_r <= 1'b1;
      vsync1_r <= 1'b1;
      de1_r    <= 1'b0;
      blank1_r <= 1'b0;
      pat1_r   <= 2'd0;
      bar_k1_r <= 3'd0;
      check1_r <= 1'b0;
      ramp1_r  <= 4'd0;
      win1_r   <= 1'b0;
    end else begin
      hsync1_r <= i_hsync;
      vsync1_r <= i_vsync;
      de1_r    <= i_de;
      blank1_r <= (state_next_s == ST_BLANK);
      pat1_r   <= pat_next_s;
      bar_k1_r <= bar_k_s;
      check1_r <= i_sx[5] ^ i_sy[5];
      ramp1_r  <= i_sx[9:6];
      win1_r   <= in_win_s;
    end
  end

  // Colour select; anything outside DE or the active window is black
  always_comb begin
    red_s   = 4'h0;
    green_s = 4'h0;
    blue_s  = 4'h0;
    if (de1_r && win1_r && !blank1_r) begin
      case (pat1_r)
        2'd0: begin
          red_s   = {4{bar_k1_r[2]}};
          green_s = {4{bar_k1_r[1]}};
          blue_s  = {4{bar_k1_r[0]}};
        end
        2'd1: begin
          red_s   = {4{check1_r}};
          green_s = {4{check1_r}};
          blue_s  = {4{check1_r}};
        end
        2'd2: begin
          red_s   = ramp1_r;
          green_s = ramp1_r;
          blue_s  = ramp1_r;
        end
        2'd3: begin
`ifdef PATTERN_SEQ_MOVING_BOX_EN
          if (box1_r) begin
            red_s   = 4'hF;
            green_s = 4'hF;
            blue_s  = 4'hF;
          end else begin
            red_s   = 4'h0;
            green_s = 4'h0;
            blue_s  = 4'h4;
          end
`else
          red_s   = 4'hF;
          green_s = 4'hF;
          blue_s  = 4'hF;
`endif
        end
        default: begin
          red_s   = 4'h0;
          green_s = 4'h0;
          blue_s  = 4'h0;
        end
      endcase
    end else begin
      red_s   = 4'h0;
      green_s = 4'h0;
      blue_s  = 4'h0;
    end
  end

  // Stage 2: colour and delayed sync/DE leave together
  always_ff @(posedge i_pix_clk) begin
    if (i_pix_rst) begin
      o_red_4b   <= 4'h0;
      o_green_4b <= 4'h0;
      o_blue_4b  <= 4'h0;
      o_hsync    <= 1'b1;
      o_vsync    <= 1'b1;
      o_de       <= 1'b0;
    end else begin
      o_red_4b   <= red_s;
      o_green_4b <= green_s;
      o_blue_4b  <= blue_s;
      o_hsync    <= hsync1_r;
      o_vsync    <= vsync1_r;
      o_de       <= de1_r;
    end
  end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Bench for vga_pattern_sequencer: frame-level model of the pattern rules, compared every cycle
// against the DUT, driven with sparse synthetic frames.
module tb_vga_pattern_sequencer;
  localparam int H = 640, V = 480, FPP = 3, BW = 80;
  localparam logic [14:0] RST_PX = {12'h000, 1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst, hs, vs, de, nx, au;
  logic [9:0] sx, sy;
  logic [3:0] r, g, b;
  logic ohs, ovs, ode;
  logic [1:0] opat;

  vga_pattern_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAMES_PER_PATTERN(FPP), .BAR_WIDTH(BW)) dut (
    .i_pix_clk(clk), .i_pix_rst(rst), .i_sx(sx), .i_sy(sy), .i_hsync(hs), .i_vsync(vs),
    .i_de(de), .i_next(nx), .i_auto(au), .o_red_4b(r), .o_green_4b(g), .o_blue_4b(b),
    .o_hsync(ohs), .o_vsync(ovs), .o_de(ode), .o_pattern(opat));

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0, cyc = 0;
  int m_pat = 0, m_shown = 1, m_box = 0;
  bit m_blank = 0, m_pending = 0;
  logic [14:0] prev_px = RST_PX;
  bit prev_rst = 1'b1, exp_valid = 1'b0, rec_en = 1'b0, rec_box = 1'b0;
  logic [16:0] exp_vec = 17'h0;
  int seq_q[$], box_q[$];

  int xs_full[20] = '{0, 1, 31, 32, 63, 64, 79, 80, 160, 240, 300, 320, 400, 480, 560, 600, 639, 640, 656, 700};
  int ys_full[6]  = '{0, 32, 230, 479, 480, 490};
  int mini_x[15]  = '{0, 5, 639, 640, 0, 1, 2, 33, 300, 607, 608, 639, 640, 0, 656};
  int mini_y[15]  = '{0, 0, 0, 0, 230, 230, 230, 230, 230, 230, 230, 230, 230, 500, 500};
  int seq_exp[17] = '{0, 0, 0, 4, 1, 1, 1, 4, 2, 2, 2, 4, 3, 3, 3, 4, 0};

  // Colour a pattern must show at (x,y) on a non-blank frame with DE high
  function automatic logic [11:0] pix(input int p, input int x, input int y);
    int k;
    logic [3:0] v;
    if (x >= H || y >= V) return 12'h000;
    case (p)
      0: begin
        k = x / BW;
        return {((k & 4) != 0) ? 4'hF : 4'h0, ((k & 2) != 0) ? 4'hF : 4'h0, ((k & 1) != 0) ? 4'hF : 4'h0};
      end
      1: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
      2: begin
        v = 4'((x >> 6) & 15);
        return {v, v, v};
      end
      default: begin
`ifdef PATTERN_SEQ_MOVING_BOX_EN
        return (x >= m_box && x <= m_box + 31 && y >= 224 && y <= 255) ? 12'hFFF : 12'h004;
`else
        return 12'hFFF;
`endif
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Frame-level model: what this input cycle must turn into at the output
  task automatic model_cycle(input int x, input int y, input bit d, input bit h, input bit v,
                             input bit n, input bit a, input bit rs, output logic [14:0] px);
    if (rs) begin
      m_pat = 0; m_blank = 0; m_shown = 1; m_pending = 0; m_box = 0;
      px = RST_PX;
      return;
    end
    if (x == 0 && y == 0) begin
      m_box = (m_box + 2 > H - 32) ? 0 : m_box + 2;
      if (m_blank) begin
        m_blank = 0; m_shown = 1; m_pending = m_pending || n;
      end else if (m_pending || n || (a && m_shown >= FPP)) begin
        m_pat = (m_pat + 1) % 4; m_blank = 1; m_pending = 0;
      end else begin
        m_shown++;
      end
    end else begin
      m_pending = m_pending || n;
    end
    px = {(d && !m_blank) ? pix(m_pat, x, y) : 12'h000, h, v, d};
  endtask

  task automatic step(input int x, input int y, input bit n, input bit a, input bit rs);
    logic [14:0] px;
    bit d, h, v;
    d = (x < H && y < V);
    h = (x != 656);
    v = !(y == 490 || y == 500);
    sx = 10'(x); sy = 10'(y); de = d; hs = h; vs = v; nx = n; au = a; rst = rs;
    model_cycle(x, y, d, h, v, n, a, rs, px);
    @(posedge clk);
    #1;
    exp_vec   = {(rs || prev_rst) ? RST_PX : prev_px, 2'(m_pat)};
    prev_px   = px;
    prev_rst  = rs;
    exp_valid = 1'b1;
    cyc++;
  endtask

  task automatic full_frame(input bit a, input int n0, input int n1, input int n2, input int rst_at);
    int c;
    bit rs;
    c = 0;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 20; j++) begin
        rs = (rst_at >= 0) && (c >= rst_at) && (c < rst_at + 3);
        step(xs_full[j], ys_full[i], (c == n0 || c == n1 || c == n2), a, rs);
        if (rs && c == rst_at) check("reset_outputs", 32'({r, g, b, ohs, ovs, ode, opat}), 32'({RST_PX, 2'b00}));
        if (c == 0 && rec_en) seq_q.push_back(m_blank ? 4 : m_pat);
        c++;
      end
    end
  endtask

  task automatic mini_frame(input bit n);
    for (int c = 0; c < 15; c++) begin
      step(mini_x[c], mini_y[c], n && (c == 2), 1'b0, 1'b0);
      if (c == 0 && rec_box) box_q.push_back(m_box);
    end
  endtask

  // Compare process: DUT outputs against the model on every cycle
  always @(negedge clk) begin
    if (exp_valid) begin
      n_checks++;
      if ({r, g, b, ohs, ovs, ode, opat} !== exp_vec) begin
        n_errors++;
        $display("FAIL out_vec cycle %0d: got %h want %h", cyc, {r, g, b, ohs, ovs, ode, opat}, exp_vec);
      end
    end
  end

  initial begin
    bit found;
    rst = 1'b1; sx = 10'd700; sy = 10'd490; hs = 1'b1; vs = 1'b0; de = 1'b0; nx = 1'b0; au = 1'b0;

    check("pin_bar_x0", 32'(pix(0, 0, 0)), 32'h000);
    check("pin_bar_x80", 32'(pix(0, 80, 0)), 32'h00F);
    check("pin_bar_x639", 32'(pix(0, 639, 0)), 32'hFFF);
    check("pin_chk_32_0", 32'(pix(1, 32, 0)), 32'hFFF);
    check("pin_chk_32_32", 32'(pix(1, 32, 32)), 32'h000);
    check("pin_ramp_639", 32'(pix(2, 639, 0)), 32'h999);

    for (int i = 0; i < 3; i++) step(700, 490, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(700, 490, 1'b0, 1'b0, 1'b0);

    full_frame(1'b0, -1, -1, -1, -1);
    full_frame(1'b0, 50, -1, -1, -1);
    check("pin_no_early_adv", 32'(m_pat), 32'd0);
    full_frame(1'b0, -1, -1, -1, -1);
    check("pin_blank_after_next", 32'({m_blank, 2'(m_pat)}), 32'({1'b1, 2'd1}));
    full_frame(1'b0, 10, 45, 90, -1);
    check("pin_show_checker", 32'({m_blank, 2'(m_pat)}), 32'({1'b0, 2'd1}));
    full_frame(1'b0, -1, -1, -1, -1);
    full_frame(1'b0, -1, -1, -1, -1);
    check("pin_coalesce", 32'({m_blank, 2'(m_pat)}), 32'({1'b0, 2'd2}));
    full_frame(1'b0, 0, 40, -1, -1);
    check("pin_fs_pulse", 32'({m_blank, 2'(m_pat)}), 32'({1'b1, 2'd3}));
    full_frame(1'b0, -1, -1, -1, -1);
    full_frame(1'b0, -1, -1, -1, -1);
    check("pin_blank_pending", 32'({m_blank, 2'(m_pat)}), 32'({1'b1, 2'd0}));

    rec_en = 1'b1;
    for (int f = 0; f < 17; f++) full_frame(1'b1, -1, -1, -1, -1);
    rec_en = 1'b0;
    check("pin_auto_len", 32'(seq_q.size()), 32'd17);
    for (int i = 0; i < 17 && i < seq_q.size(); i++) check("pin_auto_seq", 32'(seq_q[i]), 32'(seq_exp[i]));

    for (int f = 0; f < 4; f++) full_frame(1'b0, -1, -1, -1, -1);
    check("pin_saturate_hold", 32'({m_blank, 2'(m_pat)}), 32'({1'b0, 2'd0}));
    full_frame(1'b1, -1, -1, -1, -1);
    check("pin_auto_late", 32'({m_blank, 2'(m_pat)}), 32'({1'b1, 2'd1}));
    full_frame(1'b0, 30, -1, -1, -1);
    full_frame(1'b0, -1, -1, -1, 60);
    check("pin_reset_model", 32'({m_blank, 2'(m_pat)}), 32'({1'b0, 2'd0}));
    full_frame(1'b0, -1, -1, -1, -1);
    check("pin_after_reset", 32'({m_blank, 2'(m_pat)}), 32'({1'b0, 2'd0}));

    mini_frame(1'b1); mini_frame(1'b0);
    mini_frame(1'b1); mini_frame(1'b0);
    mini_frame(1'b1); mini_frame(1'b0);
    rec_box = 1'b1;
    for (int f = 0; f < 310; f++) mini_frame(1'b0);
    rec_box = 1'b0;
    check("pin_box_pattern", 32'({m_blank, 2'(m_pat)}), 32'({1'b0, 2'd3}));
    found = 1'b0;
    for (int i = 1; i + 1 < box_q.size(); i++) begin
      if (!found && box_q[i] == 608) begin
        found = 1'b1;
        check("pin_box_step", 32'(box_q[i] - box_q[i-1]), 32'd2);
        check("pin_box_wrap", 32'(box_q[i+1]), 32'd0);
      end
    end
    check("pin_box_608_seen", 32'(found), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
